// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M/RV64M multiply/divide unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_high(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shifts the next dividend bit into the partial remainder.
// Latency: combinational.
// Backpressure: none.
module muldiv_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quot_nxt
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // quot holds the not-yet-consumed dividend bits above the quotient bits built so far;
    // since rem < divisor, a set top bit of diff means the trial subtraction underflowed.
    always_comb begin
        shifted = {rem, quot[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[XLEN]) begin
            rem_nxt  = diff[XLEN-1:0];
            quot_nxt = {quot[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt  = shifted[XLEN-1:0];
            quot_nxt = {quot[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative M-extension unit: shift-add multiply (MUL_UNROLL bits/cycle), restoring divide.
// Latency: XLEN/MUL_UNROLL cycles for MUL*, XLEN for DIV*/REM*, 1 for div-by-zero/overflow.
// Backpressure: one op in flight; result held in DONE until resp_ready_i, req_ready_o only in IDLE.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1,
    parameter int TAG_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_result_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             busy_o
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("muldiv_iter_unit: XLEN must be 32 or 64");
    end
    if (!(MUL_UNROLL == 1 || MUL_UNROLL == 2 || MUL_UNROLL == 4 || MUL_UNROLL == 8)
        || (XLEN % MUL_UNROLL) != 0) begin : g_bad_unroll
        $error("muldiv_iter_unit: MUL_UNROLL must be 1, 2, 4 or 8 and divide XLEN");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("muldiv_iter_unit: TAG_W must be at least 1");
    end

    localparam int                CW       = $clog2(XLEN);
    localparam logic [CW-1:0]     MUL_K1   = CW'(XLEN / MUL_UNROLL - 1);
    localparam logic [CW-1:0]     DIV_K1   = CW'(XLEN - 1);
    localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state;
    muldiv_op_e        op_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;      // product accumulator, or {rem, quot} while dividing
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;   // multiplier bits still to retire, or the divisor
    logic              neg_q;
    logic              rem_neg_q;
    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  tag_q;

    // Accept-side decode of the raw request.
    muldiv_op_e        op_in;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              b_zero, ovf, fast;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        op_in    = muldiv_op_e'(req_op_i);
        a_neg    = op_signed_a(op_in) && req_a_i[XLEN-1];
        b_neg    = op_signed_b(op_in) && req_b_i[XLEN-1];
        a_mag    = a_neg ? -req_a_i : req_a_i;
        b_mag    = b_neg ? -req_b_i : req_b_i;
        b_zero   = (req_b_i == '0);
        ovf      = (op_in inside {OP_DIV, OP_REM}) && (req_a_i == MOST_NEG) && (req_b_i == '1);
        fast     = op_is_div(op_in) && (b_zero || ovf);
        fast_res = '0;
        if (b_zero) begin
            fast_res = op_is_rem(op_in) ? req_a_i : '1;
        end else if (ovf) begin
            fast_res = op_is_rem(op_in) ? '0 : req_a_i;
        end
    end

    logic [XLEN-1:0] rem_nxt, quot_nxt;

    muldiv_divstep #(.XLEN(XLEN)) u_divstep (
        .rem      (acc[2*XLEN-1:XLEN]),
        .quot     (acc[XLEN-1:0]),
        .divisor  (mplier),
        .rem_nxt  (rem_nxt),
        .quot_nxt (quot_nxt)
    );

    logic [2*XLEN-1:0] mul_acc_nxt;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   quot_fin, rem_fin, calc_res;

    // Sign fix-up is folded onto the last step so the result registers on the CALC->DONE edge.
    always_comb begin
        mul_acc_nxt = acc;
        for (int i = 0; i < MUL_UNROLL; i++) begin
            if (mplier[i]) begin
                mul_acc_nxt = mul_acc_nxt + (mcand << i);
            end
        end
        prod_fin = neg_q ? -mul_acc_nxt : mul_acc_nxt;
        quot_fin = neg_q ? -quot_nxt : quot_nxt;
        rem_fin  = rem_neg_q ? -rem_nxt : rem_nxt;
        if (op_is_div(op_q)) begin
            calc_res = op_is_rem(op_q) ? rem_fin : quot_fin;
        end else begin
            calc_res = op_high(op_q) ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            op_q      <= OP_MUL;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            tag_q     <= '0;
        end else if (flush_i) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_q  <= op_in;
                        tag_q <= req_tag_i;
                        if (fast) begin
                            result_q <= fast_res;
                            state    <= ST_DONE;
                        end else begin
                            neg_q     <= a_neg ^ b_neg;
                            rem_neg_q <= a_neg;
                            mplier    <= b_mag;
                            if (op_is_div(op_in)) begin
                                acc   <= {{XLEN{1'b0}}, a_mag};
                                mcand <= '0;
                                cnt   <= DIV_K1;
                            end else begin
                                acc   <= '0;
                                mcand <= {{XLEN{1'b0}}, a_mag};
                                cnt   <= MUL_K1;
                            end
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    cnt <= cnt - CW'(1);
                    if (op_is_div(op_q)) begin
                        acc <= {rem_nxt, quot_nxt};
                    end else begin
                        acc    <= mul_acc_nxt;
                        mcand  <= mcand << MUL_UNROLL;
                        mplier <= mplier >> MUL_UNROLL;
                    end
                    if (cnt == '0) begin
                        result_q <= calc_res;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o   = (state == ST_IDLE);
    assign resp_valid_o  = (state == ST_DONE);
    assign busy_o        = (state != ST_IDLE);
    assign resp_result_o = result_q;
    assign resp_tag_o    = tag_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: one XLEN=32/MUL_UNROLL=1 unit and one MUL_UNROLL=4 unit.
// Expected results and latencies are hand-computed and queued at accept; monitors pop on each new result.
module tb_muldiv_iter_unit;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    // Fast-path results are visible in the cycle right after the accepting edge (zero extra edges).
    localparam int FAST = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        flush1 = 1'b0, req_vld1 = 1'b0, req_rdy1, resp_vld1, resp_rdy1 = 1'b1, busy1;
    logic [2:0]  op1 = '0;
    logic [31:0] a1 = '0, b1 = '0, res1;
    logic [4:0]  tag1 = '0, rtag1;

    logic        flush4 = 1'b0, req_vld4 = 1'b0, req_rdy4, resp_vld4, resp_rdy4 = 1'b1, busy4;
    logic [2:0]  op4 = '0;
    logic [31:0] a4 = '0, b4 = '0, res4;
    logic [4:0]  tag4 = '0, rtag4;

    muldiv_iter_unit #(.XLEN(32), .MUL_UNROLL(1), .TAG_W(5)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush1),
        .req_valid_i(req_vld1), .req_ready_o(req_rdy1), .req_op_i(op1),
        .req_a_i(a1), .req_b_i(b1), .req_tag_i(tag1),
        .resp_valid_o(resp_vld1), .resp_ready_i(resp_rdy1),
        .resp_result_o(res1), .resp_tag_o(rtag1), .busy_o(busy1)
    );

    muldiv_iter_unit #(.XLEN(32), .MUL_UNROLL(4), .TAG_W(5)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush4),
        .req_valid_i(req_vld4), .req_ready_o(req_rdy4), .req_op_i(op4),
        .req_a_i(a4), .req_b_i(b4), .req_tag_i(tag4),
        .resp_valid_o(resp_vld4), .resp_ready_i(resp_rdy4),
        .resp_result_o(res4), .resp_tag_o(rtag4), .busy_o(busy4)
    );

    exp_t q1[$];
    exp_t q4[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic monitor(input bit u4);
        bit          prev = 1'b0;
        bit          have = 1'b0;
        exp_t        cur;
        logic        v, rr;
        logic [31:0] r;
        logic [4:0]  t;
        int          pending;
        string       p;
        p = u4 ? "u4" : "u1";
        forever begin
            @(negedge clk);
            v  = u4 ? resp_vld4 : resp_vld1;
            rr = u4 ? req_rdy4 : req_rdy1;
            r  = u4 ? res4 : res1;
            t  = u4 ? rtag4 : rtag1;
            pending = u4 ? q4.size() : q1.size();
            if (v && !prev) begin
                if (pending == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_unexpected_resp actual=valid result=%h required=no response", p, r);
                end else begin
                    if (u4) cur = q4.pop_front();
                    else    cur = q1.pop_front();
                    have = 1'b1;
                    check({p, "_latency"}, 32'(cyc - cur.acc), 32'(cur.lat));
                end
            end
            if (v && have) begin
                check({p, "_result"}, r, cur.res);
                check({p, "_tag"}, 32'(t), 32'(cur.tag));
                check({p, "_req_ready_in_done"}, 32'(rr), 32'd0);
            end
            if (!v) have = 1'b0;
            prev = v;
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    task automatic send(input bit u4, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int lat, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!(u4 ? req_rdy4 : req_rdy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout op=%0d actual=not ready required=ready", op);
            return;
        end
        if (u4) begin
            req_vld4 = 1'b1; op4 = op; a4 = a; b4 = b; tag4 = tag;
        end else begin
            req_vld1 = 1'b1; op1 = op; a1 = a; b1 = b; tag1 = tag;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.res = exp; e.tag = tag; e.acc = cyc; e.lat = lat;
            if (u4) q4.push_back(e);
            else    q1.push_back(e);
        end
        req_vld1 = 1'b0;
        req_vld4 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0 || busy1 || busy4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q1.size(), q4.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_rdy1), 32'd1);
        check("rst_resp_valid", 32'(resp_vld1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_result", res1, 32'd0);
        check("rst_tag", 32'(rtag1), 32'd0);
        rst = 1'b0;

        send(0, MUL,    32'd6,          32'd7,          5'd3,  32'd42,         32,   1);
        send(0, MUL,    32'hFFFFFFFE,   32'd3,          5'd4,  32'hFFFFFFFA,   32,   1);
        send(0, MULH,   32'h80000000,   32'h80000000,   5'd5,  32'h40000000,   32,   1);
        send(0, MULH,   32'hFFFFFFFE,   32'd3,          5'd6,  32'hFFFFFFFF,   32,   1);
        send(0, MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd7,  32'hFFFFFFFF,   32,   1);
        send(0, MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   5'd8,  32'hFFFFFFFE,   32,   1);
        send(0, DIV,    32'hFFFFFFEC,   32'd3,          5'd9,  32'hFFFFFFFA,   32,   1);
        send(0, REM,    32'hFFFFFFEC,   32'd3,          5'd10, 32'hFFFFFFFE,   32,   1);
        send(0, DIV,    32'd20,         32'hFFFFFFFD,   5'd11, 32'hFFFFFFFA,   32,   1);
        send(0, REM,    32'd20,         32'hFFFFFFFD,   5'd12, 32'd2,          32,   1);
        send(0, DIVU,   32'd20,         32'd4,          5'd13, 32'd5,          32,   1);
        send(0, REMU,   32'd21,         32'd4,          5'd14, 32'd1,          32,   1);
        send(0, DIVU,   32'h80000000,   32'hFFFFFFFF,   5'd15, 32'd0,          32,   1);
        send(0, DIV,    32'd7,          32'd0,          5'd16, 32'hFFFFFFFF,   FAST, 1);
        send(0, REM,    32'd7,          32'd0,          5'd17, 32'd7,          FAST, 1);
        send(0, DIVU,   32'd9,          32'd0,          5'd18, 32'hFFFFFFFF,   FAST, 1);
        send(0, REMU,   32'd9,          32'd0,          5'd19, 32'd9,          FAST, 1);
        send(0, DIV,    32'h80000000,   32'hFFFFFFFF,   5'd20, 32'h80000000,   FAST, 1);
        send(0, REM,    32'h80000000,   32'hFFFFFFFF,   5'd21, 32'd0,          FAST, 1);

        send(1, MUL,    32'd6,          32'd7,          5'd22, 32'd42,         8,    1);
        send(1, MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   5'd23, 32'hFFFFFFFE,   8,    1);
        send(1, MULH,   32'hFFFFFFFE,   32'd3,          5'd24, 32'hFFFFFFFF,   8,    1);
        drain();

        // Backpressure: result and tag must hold while the consumer stalls.
        resp_rdy1 = 1'b0;
        send(0, DIVU, 32'd20, 32'd4, 5'd25, 32'd5, 32, 1);
        n = 0;
        while (!resp_vld1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_seen", 32'(resp_vld1), 32'd1);
        repeat (5) begin
            check("hold_req_ready", 32'(req_rdy1), 32'd0);
            check("hold_resp_valid", 32'(resp_vld1), 32'd1);
            @(negedge clk);
        end
        resp_rdy1 = 1'b1;
        @(posedge clk);
        #1;
        check("release_idle", 32'(req_rdy1), 32'd1);
        check("release_valid_low", 32'(resp_vld1), 32'd0);
        send(0, REMU, 32'd21, 32'd4, 5'd26, 32'd1, 32, 1);
        drain();

        // Flush mid-divide: the result must never appear.
        send(0, DIV, 32'd100, 32'd7, 5'd27, 32'd0, 0, 0);
        repeat (10) @(negedge clk);
        flush1 = 1'b1;
        @(posedge clk);
        #1;
        flush1 = 1'b0;
        check("flush_req_ready", 32'(req_rdy1), 32'd1);
        check("flush_busy", 32'(busy1), 32'd0);
        check("flush_resp_valid", 32'(resp_vld1), 32'd0);
        repeat (45) @(negedge clk);

        // Reset mid-multiply: outputs return to reset values on the next edge.
        send(0, MUL, 32'd123, 32'd456, 5'd28, 32'd0, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_req_ready", 32'(req_rdy1), 32'd1);
        check("midrst_resp_valid", 32'(resp_vld1), 32'd0);
        check("midrst_busy", 32'(busy1), 32'd0);
        check("midrst_result", res1, 32'd0);
        check("midrst_tag", 32'(rtag1), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Flush wins over a request presented in IDLE.
        @(negedge clk);
        req_vld1 = 1'b1; op1 = MUL; a1 = 32'd5; b1 = 32'd5; tag1 = 5'd29;
        flush1 = 1'b1;
        @(posedge clk);
        #1;
        req_vld1 = 1'b0;
        flush1 = 1'b0;
        check("flush_idle_busy", 32'(busy1), 32'd0);
        check("flush_idle_req_ready", 32'(req_rdy1), 32'd1);
        repeat (40) @(negedge clk);

        send(0, MUL, 32'd5, 32'd5, 5'd30, 32'd25, 32, 1);
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
